// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, jump opcodes,
// the nop encoding and a PC increment helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package ifetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   localparam logic [5:0]  EXE_J     = 6'b000010;
   localparam logic [5:0]  EXE_JAL   = 6'b000011;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Sequential PC advance; wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_unit_next_pc.sv
// next_pc_logic: selects the PC that follows the retiring instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only commits next_pc when execute retires.
//
// Ports: pc / jump_index (Instruction[25:0]) / control strobes jr, jmp, jal,
//        branch, nbranch / ALU zero and addr_result / read_data_1 (jr target)
//        -> next_pc. With IFETCH_MISALIGN_TRAP_EN defined, also drives
//        misalign, set when a jr target is not word aligned.
import ifetch_unit_pkg::*;

module next_pc_logic #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic [31:0] pc,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic        jmp,
   input  logic        jal,
   input  logic        branch,
   input  logic        nbranch,
   input  logic        zero,
   input  logic [31:0] addr_result,
   input  logic [31:0] read_data_1,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic [31:0] next_pc
);

   logic [31:0] pc_plus4;
   logic [31:0] jr_target;
   logic [31:0] jump_target;
   logic        branch_taken;

   assign pc_plus4     = pc_inc(pc);
   // Word-aligned register target; a misaligned rs never reaches the PC.
   assign jr_target    = read_data_1 & 32'hFFFF_FFFC;
   // Pseudo-direct jump stays inside the current 256 MB region of pc+4.
   assign jump_target  = {pc_plus4[31:28], jump_index, 2'b00};
   assign branch_taken = (branch & zero) | (nbranch & ~zero);

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign = jr & (read_data_1[1:0] != 2'b00);
`endif

   always_comb begin
      next_pc = pc_plus4;
      if (jr) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
         next_pc = misalign ? EXC_VECTOR : jr_target;
`else
         next_pc = jr_target;
`endif
      end else if (jmp || jal) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = addr_result;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: holds the PC, fetches one instruction word at a time and hands it to execute.
// Latency: one idle cycle out of reset, then >=1 cycle per fetch (unbounded wait states), one exec cycle minimum.
// Backpressure: stall holds PC, Instruction and instr_valid in S_EXEC; imem_valid is the memory-side handshake.
//
// Ports: clock, rst_n (synchronous, active-low); imem_req/imem_addr/imem_rdata/imem_valid
//        to instruction memory; stall from downstream; Addr_Result, Zero, Read_data_1 and
//        Branch/nBranch/Jmp/Jal/Jr from ALU and control; Instruction, instr_valid,
//        branch_base_addr (pc+4), link_addr, pc_out towards execute.
// Optional: define IFETCH_MISALIGN_TRAP_EN to add misalign_exc and epc; a misaligned jr
//        then vectors to EXC_VECTOR instead of silently dropping the low address bits.
import ifetch_unit_pkg::*;

module ifetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_ADDR_W = 14,
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080
) (
   input  logic                   clock,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]            imem_rdata,
   input  logic                   imem_valid,
   input  logic                   stall,
   input  logic [31:0]            Addr_Result,
   input  logic                   Zero,
   input  logic [31:0]            Read_data_1,
   input  logic                   Branch,
   input  logic                   nBranch,
   input  logic                   Jmp,
   input  logic                   Jal,
   input  logic                   Jr,
   output logic [31:0]            Instruction,
   output logic                   instr_valid,
   output logic [31:0]            branch_base_addr,
   output logic [31:0]            link_addr,
   output logic [31:0]            pc_out
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                   misalign_exc,
   output logic [31:0]            epc
`endif
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        jr_misalign;
`endif

   assign pc_plus4         = pc_inc(pc);
   assign branch_base_addr = pc_plus4;
   assign pc_out           = pc;
   // pc only changes on an exec retire, so the address is stable for the whole fetch.
   assign imem_addr        = pc[IMEM_ADDR_W+1:2];

   next_pc_logic #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc (
      .pc          (pc),
      .jump_index  (Instruction[25:0]),
      .jr          (Jr),
      .jmp         (Jmp),
      .jal         (Jal),
      .branch      (Branch),
      .nbranch     (nBranch),
      .zero        (Zero),
      .addr_result (Addr_Result),
      .read_data_1 (Read_data_1),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .misalign    (jr_misalign),
`endif
      .next_pc     (next_pc)
   );

   // imem_req is registered: raised on every transition into S_FETCH and
   // dropped on the handshake edge, so it is high exactly while in S_FETCH.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pc           <= RESET_PC;
         Instruction  <= NOP_INSTR;
         instr_valid  <= 1'b0;
         link_addr    <= 32'h0;
         imem_req     <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_exc <= 1'b0;
         epc          <= 32'h0;
`endif
      end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_exc <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // Any stray imem_valid here belongs to an abandoned request.
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_valid) begin
                  Instruction <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= S_FETCH;
                  if (Jal) begin
                     link_addr <= pc_plus4;
                  end
`ifdef IFETCH_MISALIGN_TRAP_EN
                  if (jr_misalign) begin
                     epc          <= pc;
                     misalign_exc <= 1'b1;
                  end
`endif
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic [31:0] Addr_Result;
   logic        Zero;
   logic [31:0] Read_data_1;
   logic        Branch, nBranch, Jmp, Jal, Jr;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic [31:0] branch_base_addr;
   logic [31:0] link_addr;
   logic [31:0] pc_out;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ifetch_unit dut (
      .clock            (clock),
      .rst_n            (rst_n),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .imem_valid       (imem_valid),
      .stall            (stall),
      .Addr_Result      (Addr_Result),
      .Zero             (Zero),
      .Read_data_1      (Read_data_1),
      .Branch           (Branch),
      .nBranch          (nBranch),
      .Jmp              (Jmp),
      .Jal              (Jal),
      .Jr               (Jr),
      .Instruction      (Instruction),
      .instr_valid      (instr_valid),
      .branch_base_addr (branch_base_addr),
      .link_addr        (link_addr),
      .pc_out           (pc_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
      Addr_Result = 32'h0; Read_data_1 = 32'h0; stall = 0;
   endtask

   // Entered at a negedge while in S_FETCH; memory answers after 'waits' cycles.
   task automatic do_fetch(input logic [31:0] w, input int waits, input string tag);
      imem_valid = 0;
      repeat (waits) @(negedge clock);
      imem_valid = 1;
      imem_rdata = w;
      @(negedge clock);
      imem_valid = 0;
      chk({tag, "_instr"}, Instruction, w);
      chk({tag, "_ivld"}, {31'b0, instr_valid}, 32'd1);
      chk({tag, "_req_lo"}, {31'b0, imem_req}, 32'd0);
   endtask

   // Controls must already be set; retires on the next posedge.
   task automatic retire(input logic [31:0] exp_pc, input string tag);
      @(negedge clock);
      clear_ctrl();
      chk({tag, "_pc"}, pc_out, exp_pc);
      chk({tag, "_ivld0"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, "_req_hi"}, {31'b0, imem_req}, 32'd1);
   endtask

   initial begin
      rst_n = 0; imem_valid = 0; imem_rdata = 32'h0;
      clear_ctrl();

      // Reset held for two edges.
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_ivld", {31'b0, instr_valid}, 32'd0);
      chk("rst_link", link_addr, 32'h0);
      chk("rst_instr", Instruction, 32'h0);
      rst_n = 1;
      @(negedge clock);
      chk("rel_req", {31'b0, imem_req}, 32'd1);
      chk("rel_addr", {18'b0, imem_addr}, 32'h0);

      // Sequential fetch, one wait state.
      do_fetch(32'h2008_0005, 1, "seq");
      chk("seq_bba", branch_base_addr, 32'h4);
      retire(32'h4, "seq");
      chk("seq_addr", {18'b0, imem_addr}, 32'h1);

      // pc 4 -> 8
      do_fetch(32'h0000_0000, 0, "nop4");
      retire(32'h8, "nop4");

      // beq taken at 0x8
      do_fetch(32'h1000_000E, 0, "beqT");
      Branch = 1; Zero = 1; Addr_Result = 32'h40;
      retire(32'h40, "beqT");

      // j back to 0x8
      do_fetch(32'h0800_0002, 0, "j8a");
      Jmp = 1;
      retire(32'h8, "j8a");

      // beq not taken at 0x8
      do_fetch(32'h1000_000E, 0, "beqN");
      Branch = 1; Zero = 0; Addr_Result = 32'h40;
      retire(32'hC, "beqN");

      // j back to 0x8
      do_fetch(32'h0800_0002, 0, "j8b");
      Jmp = 1;
      retire(32'h8, "j8b");

      // bne taken at 0x8
      do_fetch(32'h1400_000E, 0, "bneT");
      nBranch = 1; Zero = 0; Addr_Result = 32'h40;
      retire(32'h40, "bneT");

      // j to 0x10
      do_fetch(32'h0800_0004, 0, "j10");
      Jmp = 1;
      retire(32'h10, "j10");

      // jal at 0x10 -> 0x80, link 0x14
      do_fetch(32'h0C00_0020, 2, "jal");
      chk("jal_bba", branch_base_addr, 32'h14);
      Jal = 1;
      retire(32'h80, "jal");
      chk("jal_link", link_addr, 32'h14);

      // Stall 3 cycles then jr + j together; jr wins.
      do_fetch(32'h0000_0008, 0, "stl");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("stl_pc", pc_out, 32'h80);
         chk("stl_instr", Instruction, 32'h0000_0008);
         chk("stl_ivld", {31'b0, instr_valid}, 32'd1);
      end
      stall = 0; Jr = 1; Jmp = 1; Read_data_1 = 32'h100;
      retire(32'h100, "jrpri");
      chk("jr_link_held", link_addr, 32'h14);

      // Misaligned jr target: low bits dropped.
      do_fetch(32'h0000_0008, 0, "jrmis");
      Jr = 1; Read_data_1 = 32'h203;
      retire(32'h200, "jrmis");

      // jr to top of memory, then wrap.
      do_fetch(32'h0000_0008, 0, "jrtop");
      Jr = 1; Read_data_1 = 32'hFFFF_FFFC;
      retire(32'hFFFF_FFFC, "jrtop");
      chk("top_addr", {18'b0, imem_addr}, 32'h3FFF);
      do_fetch(32'h0000_0000, 0, "wrap");
      chk("wrap_bba", branch_base_addr, 32'h0);
      retire(32'h0, "wrap");

      // j beats a taken branch.
      do_fetch(32'h0800_0010, 0, "jpri");
      Jmp = 1; Branch = 1; Zero = 1; Addr_Result = 32'h80;
      retire(32'h40, "jpri");

      // Reset mid-fetch, memory answers only after release.
      do_fetch(32'h0000_0000, 0, "pre");
      retire(32'h44, "pre");
      rst_n = 0;
      repeat (3) @(negedge clock);
      chk("mid_pc", pc_out, 32'h0);
      chk("mid_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1; imem_valid = 1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      imem_valid = 0;
      chk("late_ivld", {31'b0, instr_valid}, 32'd0);
      chk("late_instr", Instruction, 32'h0);
      chk("late_req", {31'b0, imem_req}, 32'd1);
      chk("late_addr", {18'b0, imem_addr}, 32'h0);
      @(negedge clock);
      chk("late_still_fetch", {31'b0, instr_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
